// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
// Imported by the fetch interface, the skid buffer and the fetch_stage top.
package fetch_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 16;
    localparam logic [AW_DEFAULT-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int PC_INC_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] inst;
        logic [AW_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
interface fetch_stage_if
    import fetch_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that arrived while decode was stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t entry
);

    logic         valid_reg;
    fetch_entry_t entry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            entry_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            entry_reg <= din;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign entry = entry_reg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives the next PC, runs the imem req/ack handshake and owns the IF/ID
// register, with a one-entry skid buffer absorbing a word that lands during a stall.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int            AW       = AW_DEFAULT,
    parameter int            DW       = DW_DEFAULT,
    parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [AW-1:0] PC_INC   = AW'(PC_INC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        pc,
    output logic [AW-1:0]        npc,
    fetch_stage_if.master        imem,
    input  logic                 branch_taken,
    input  logic [AW-1:0]        branch_target,
    input  logic                 stall,
    output logic                 inst_valid,
    output logic [DW-1:0]        inst,
    output logic [AW-1:0]        inst_pc
);

    fetch_state_t  state_reg, state_next;
    logic          req_reg, req_next;
    logic [AW-1:0] addr_reg, addr_next;

    logic          inst_valid_reg;
    logic [DW-1:0] inst_reg;
    logic [AW-1:0] inst_pc_reg;

    logic          skid_valid;
    fetch_entry_t  skid_entry;
    fetch_entry_t  skid_din;

    logic          blocked;
    logic          accept;
    logic          skid_load;
    logic          skid_drain;

    // A word may only be requested when it is guaranteed a place to land.
    assign blocked    = skid_valid | (inst_valid_reg & stall);
    assign accept     = (state_reg == REQ) & imem.imem_ack & ~branch_taken;
    assign skid_load  = accept & inst_valid_reg & stall;
    assign skid_drain = ~branch_taken & ~accept & ~stall & skid_valid;
    assign skid_din   = '{inst: imem.imem_rdata, pc: addr_reg};

    always_comb begin
        npc = pc;
        if (rst) begin
            npc = RESET_PC;
        end else if (branch_taken) begin
            npc = branch_target;
        end else if (accept) begin
            npc = addr_reg + PC_INC;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        addr_next  = addr_reg;
        case (state_reg)
            IDLE: begin
                if (!blocked && !branch_taken) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    addr_next  = pc;
                end
            end
            REQ: begin
                if (!imem.imem_ack) begin
                    // The outstanding request cannot be withdrawn; its data is dropped in KILL.
                    if (branch_taken) begin
                        state_next = KILL;
                    end
                end else if (branch_taken) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end else if (!stall) begin
                    addr_next = addr_reg + PC_INC;
                end else begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            KILL: begin
                if (imem.imem_ack) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            addr_reg  <= addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
        end else if (branch_taken) begin
            inst_valid_reg <= 1'b0;
        end else if (accept && !skid_load) begin
            inst_valid_reg <= 1'b1;
            inst_reg       <= imem.imem_rdata;
            inst_pc_reg    <= addr_reg;
        end else if (!accept && !stall) begin
            if (skid_valid) begin
                inst_valid_reg <= 1'b1;
                inst_reg       <= skid_entry.inst;
                inst_pc_reg    <= skid_entry.pc;
            end else begin
                inst_valid_reg <= 1'b0;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (branch_taken),
        .din   (skid_din),
        .valid (skid_valid),
        .entry (skid_entry)
    );

    assign imem.imem_req  = req_reg;
    assign imem.imem_addr = addr_reg;
    assign inst_valid     = inst_valid_reg;
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed handshake scenarios, then random stall/branch/latency
// traffic checked against the expected program-order instruction stream.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = '0;
    logic [15:0] npc;
    logic        bt = 1'b0;
    logic [15:0] bt_target = '0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;

    int n_chk = 0;
    int n_pass = 0;

    fetch_stage_if imif ();

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .npc           (npc),
        .imem          (imif),
        .branch_taken  (bt),
        .branch_target (bt_target),
        .stall         (stall),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    // PC register loads npc on every edge.
    always @(posedge clk) pc <= npc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks each request after 0..max_wait wait cycles.
    bit mem_auto = 1'b0;
    int max_wait = 0;
    int wait_cnt = 0;
    int wait_tgt = 0;

    always @(posedge clk) begin
        #2;
        if (mem_auto) begin
            if (imif.imem_req) begin
                if (wait_cnt >= wait_tgt) begin
                    imif.imem_ack   = 1'b1;
                    imif.imem_rdata = mem_word(imif.imem_addr);
                    wait_cnt        = 0;
                    wait_tgt        = int'($urandom_range(max_wait, 0));
                end else begin
                    imif.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imif.imem_ack = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    // Scoreboard: expected program-order stream; a branch restarts it at the target.
    bit           sb_on = 1'b0;
    fetch_entry_t exp_q[$];
    int           n_consumed = 0;
    logic         prev_req = 1'b0;
    logic         prev_ack = 1'b0;
    logic [15:0]  prev_addr = '0;

    always @(negedge clk) begin
        if (sb_on) begin
            if (prev_req && !prev_ack) begin
                chk16("req_hold", 16'(imif.imem_req), 16'd1);
                chk16("addr_hold", imif.imem_addr, prev_addr);
            end
            prev_req  = imif.imem_req;
            prev_ack  = imif.imem_ack;
            prev_addr = imif.imem_addr;
            if (inst_valid && !stall && !bt) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: got pc %h, expected no instruction", inst_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    $display("txn pc=%h inst=%h exp_pc=%h exp_inst=%h", inst_pc, inst, e.pc, e.inst);
                    chk16("sb_pc", inst_pc, e.pc);
                    chk16("sb_inst", inst, e.inst);
                    exp_q.push_back('{inst: mem_word(16'(e.pc + 16'd1)), pc: 16'(e.pc + 16'd1)});
                end
                n_consumed++;
            end
        end
    end

    task automatic do_reset();
        rst             = 1'b1;
        bt              = 1'b0;
        stall           = 1'b0;
        mem_auto        = 1'b0;
        imif.imem_ack   = 1'b0;
        imif.imem_rdata = '0;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] t;
        imif.imem_ack   = 1'b0;
        imif.imem_rdata = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk16("rst_req", 16'(imif.imem_req), 16'd0);
        chk16("rst_addr", imif.imem_addr, 16'd0);
        chk16("rst_valid", 16'(inst_valid), 16'd0);
        chk16("rst_inst", inst, 16'd0);
        chk16("rst_inst_pc", inst_pc, 16'd0);
        chk16("rst_npc", npc, RESET_PC_DEFAULT);

        // Zero-wait back-to-back fetch
        cyc();
        rst      = 1'b0;
        max_wait = 0;
        wait_cnt = 0;
        wait_tgt = 0;
        mem_auto = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge clk);
            chk16("zw_addr", imif.imem_addr, 16'(k));
            chk16("zw_npc", npc, 16'(k + 1));
            if (k == 0) begin
                chk16("zw_valid0", 16'(inst_valid), 16'd0);
            end else begin
                chk16("zw_valid", 16'(inst_valid), 16'd1);
                chk16("zw_inst_pc", inst_pc, 16'(k - 1));
                chk16("zw_inst", inst, mem_word(16'(k - 1)));
            end
        end

        // Reset mid-request, then a stray ack
        cyc();
        mem_auto      = 1'b0;
        imif.imem_ack = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        chk16("mid_pc", pc, 16'd4);
        chk16("mid_rst_npc", npc, RESET_PC_DEFAULT);
        cyc();
        rst             = 1'b0;
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = 16'hDEAD;
        @(negedge clk);
        chk16("mid_req", 16'(imif.imem_req), 16'd0);
        chk16("mid_addr", imif.imem_addr, 16'd0);
        chk16("mid_valid", 16'(inst_valid), 16'd0);
        chk16("mid_inst", inst, 16'd0);
        chk16("mid_inst_pc", inst_pc, 16'd0);
        chk16("mid_npc", npc, 16'd0);
        cyc();
        imif.imem_ack = 1'b0;
        @(negedge clk);
        chk16("stray_valid", 16'(inst_valid), 16'd0);
        chk16("stray_req", 16'(imif.imem_req), 16'd1);
        chk16("stray_addr", imif.imem_addr, 16'd0);
        cyc();
        @(negedge clk);
        chk16("stray_valid2", 16'(inst_valid), 16'd0);

        // Stall with a request in flight: skid capture and in-order drain
        do_reset();
        cyc();
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = mem_word(16'd0);
        cyc();
        imif.imem_ack = 1'b0;
        stall         = 1'b1;
        cyc();
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = mem_word(16'd1);
        cyc();
        imif.imem_ack = 1'b0;
        @(negedge clk);
        chk16("stl_req", 16'(imif.imem_req), 16'd0);
        chk16("stl_npc", npc, 16'd2);
        chk16("stl_inst_pc", inst_pc, 16'd0);
        cyc();
        stall = 1'b0;
        @(negedge clk);
        chk16("stl_hold_valid", 16'(inst_valid), 16'd1);
        chk16("stl_hold_pc", inst_pc, 16'd0);
        chk16("stl_hold_inst", inst, mem_word(16'd0));
        cyc();
        @(negedge clk);
        chk16("skid_pc", inst_pc, 16'd1);
        chk16("skid_inst", inst, mem_word(16'd1));
        chk16("skid_req", 16'(imif.imem_req), 16'd0);
        cyc();
        @(negedge clk);
        chk16("resume_req", 16'(imif.imem_req), 16'd1);
        chk16("resume_addr", imif.imem_addr, 16'd2);
        chk16("resume_valid", 16'(inst_valid), 16'd0);

        // Branch while a request waits: KILL discards the late data
        do_reset();
        cyc();
        cyc();
        bt        = 1'b1;
        bt_target = 16'h0040;
        @(negedge clk);
        chk16("kill_npc", npc, 16'h0040);
        cyc();
        bt = 1'b0;
        cyc();
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = mem_word(16'd0);
        @(negedge clk);
        chk16("kill_req", 16'(imif.imem_req), 16'd1);
        chk16("kill_addr", imif.imem_addr, 16'd0);
        cyc();
        imif.imem_ack = 1'b0;
        @(negedge clk);
        chk16("kill_valid", 16'(inst_valid), 16'd0);
        chk16("kill_req_drop", 16'(imif.imem_req), 16'd0);
        cyc();
        @(negedge clk);
        chk16("redir_addr", imif.imem_addr, 16'h0040);
        chk16("redir_req", 16'(imif.imem_req), 16'd1);
        chk16("redir_valid", 16'(inst_valid), 16'd0);

        // Branch coincident with ack
        do_reset();
        cyc();
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = mem_word(16'd0);
        bt              = 1'b1;
        bt_target       = 16'h0100;
        @(negedge clk);
        chk16("co_npc", npc, 16'h0100);
        cyc();
        imif.imem_ack = 1'b0;
        bt            = 1'b0;
        @(negedge clk);
        chk16("co_valid", 16'(inst_valid), 16'd0);
        chk16("co_req", 16'(imif.imem_req), 16'd0);
        cyc();
        @(negedge clk);
        chk16("co_addr", imif.imem_addr, 16'h0100);
        chk16("co_valid2", 16'(inst_valid), 16'd0);

        // PC wrap at 16'hFFFF
        do_reset();
        bt        = 1'b1;
        bt_target = 16'hFFFF;
        cyc();
        bt = 1'b0;
        cyc();
        imif.imem_ack   = 1'b1;
        imif.imem_rdata = mem_word(16'hFFFF);
        @(negedge clk);
        chk16("wrap_req_addr", imif.imem_addr, 16'hFFFF);
        chk16("wrap_npc", npc, 16'h0000);
        cyc();
        imif.imem_ack = 1'b0;
        @(negedge clk);
        chk16("wrap_addr", imif.imem_addr, 16'h0000);
        chk16("wrap_inst_pc", inst_pc, 16'hFFFF);
        chk16("wrap_valid", 16'(inst_valid), 16'd1);
        chk16("wrap_pc", pc, 16'h0000);

        // Random stall / branch / memory latency traffic
        do_reset();
        exp_q.delete();
        exp_q.push_back('{inst: mem_word(16'd0), pc: 16'd0});
        prev_req = 1'b0;
        prev_ack = 1'b0;
        max_wait = 3;
        wait_cnt = 0;
        wait_tgt = 0;
        mem_auto = 1'b1;
        sb_on    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(99, 0) < 30);
            bt    = ($urandom_range(99, 0) < 4);
            if (bt) begin
                t         = 16'($urandom);
                bt_target = t;
                exp_q.delete();
                exp_q.push_back('{inst: mem_word(t), pc: t});
            end
        end
        cyc();
        sb_on = 1'b0;
        bt    = 1'b0;
        stall = 1'b0;
        n_chk++;
        if (n_consumed >= 200) n_pass++;
        else $display("FAIL liveness: got %0d instructions, expected at least 200", n_consumed);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage that sits around the 16-bit PC register.
- Consumes the registered `pc` and generates `npc`, which the PC register loads unconditionally on every `clk` edge.
- Issues requests to instruction memory with a req/ack handshake and presents fetched words to decode through a registered IF/ID output with stall, plus a one-entry skid buffer.
- Handles taken-branch redirect and flush from a later stage.

Parameters:
- AW, 16, address / PC width.
- DW, 16, instruction word width.
- RESET_PC, 16'h0000, value driven on `npc` while `rst` is high.
- PC_INC, 1, PC increment per fetched word (word-addressed memory).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  input  AW  current PC from the PC register.
- npc  output  AW  next PC, combinational, fed to the PC register.
- imem_req  output  1  registered memory request; held high until `imem_ack`.
- imem_addr  output  AW  registered request address; stable while `imem_req` is high.
- imem_ack  input  1  single-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- imem_rdata  input  DW  instruction word.
- branch_taken  input  1  redirect and flush request.
- branch_target  input  AW  redirect address.
- stall  input  1  decode cannot accept `inst` this cycle.
- inst_valid  output  1  IF/ID register holds a valid instruction.
- inst  output  DW  IF/ID instruction.
- inst_pc  output  AW  address of `inst`.

Behaviour:
- Reset:
  - state=IDLE, imem_req=0, imem_addr=0.
  - inst_valid=0, inst=0, inst_pc=0, skid_valid=0.
  - npc=RESET_PC combinationally while rst=1, so `pc` equals RESET_PC after the first reset edge.
  - Reset mid-request drops the request; any later stray ack is ignored in IDLE.
- npc priority:
  - rst → RESET_PC.
  - branch_taken → branch_target.
  - accepted ack → imem_addr+PC_INC (mod 2^AW; wrap 16'hFFFF→16'h0000 is legal).
  - otherwise pc (hold).
- "blocked" = skid_valid | (inst_valid & stall).
- IDLE:
  - If !blocked and !branch_taken: go to REQ, imem_req<=1, imem_addr<=pc.
  - If branch_taken: stay in IDLE; npc redirects the PC.
- REQ, imem_ack=0:
  - Keep req and addr.
  - If branch_taken: go to KILL (req stays high at the old address).
- REQ, imem_ack=1, branch_taken=1:
  - Discard rdata and go to IDLE with imem_req<=0.
- REQ, imem_ack=1, branch_taken=0 (accepted ack):
  - If inst_valid & stall: write {rdata, imem_addr} into the skid buffer; skid_valid<=1.
  - Otherwise: inst<=rdata, inst_pc<=imem_addr, inst_valid<=1.
  - If stall=0 and no skid write: stay in REQ with imem_addr<=imem_addr+PC_INC (back-to-back, 1 word/cycle at zero-wait).
  - Otherwise go to IDLE with imem_req<=0.
- KILL:
  - Hold req and addr until imem_ack; discard data; go to IDLE with imem_req<=0.
  - branch_taken in KILL only updates npc (the latest redirect wins).
- IF/ID register when no ack lands:
  - stall=0 with skid_valid: load the skid contents into inst/inst_pc, skid_valid<=0.
  - stall=0 without skid: inst_valid<=0.
- Flush: branch_taken clears inst_valid and skid_valid on the next edge, taking priority over all loads.
- Simultaneous stall and accepted ack with inst_valid=0: load inst directly (no skid), then go to IDLE.
- skid_valid=1 and inst_valid=0 can never occur.
- Latency: request issued one cycle after IDLE sees !blocked; inst_valid rises the edge after the ack.

Decomposition:
- Package `fetch_pkg`:
  - state enum {IDLE, REQ, KILL}.
  - AW/DW defaults, RESET_PC, PC_INC.
  - typedef fetch_entry_t {inst, pc}.
- Sub-module `fetch_skid_buf`: one-entry buffer (load, drain, flush, valid, entry). The FSM and npc mux stay in the top module.

Test Plan:
- Reset, then release with imem_ack tied to imem_req (zero-wait), rdata=addr^16'hA5A5:
  - imem_addr sequence 0,1,2,3.
  - inst_valid high from cycle 3 with inst_pc 0,1,2.
  - npc=pc+1 each ack.
- stall asserted for 3 cycles while a request is in flight:
  - Skid captures the word, imem_req drops, npc holds.
  - After release, inst shows the held word, then the skid word, then fetch resumes at the next address; no word is lost or duplicated.
- branch_taken with target 16'h0040 while REQ is waiting (ack 2 cycles later):
  - State goes to KILL, the late rdata is discarded, inst_valid=0.
  - The next request has imem_addr=0x0040.
- branch_taken coincident with imem_ack: rdata dropped; npc=target; no inst_valid pulse.
- PC at 16'hFFFF with an accepted ack: npc=16'h0000 and the next imem_addr=0.
- rst asserted mid-REQ, with a stray ack arriving after reset:
  - All outputs return to reset values; npc=RESET_PC.
  - The ack is ignored and no instruction is produced.
